hex_display_ctrl: RTL and testbench

Parametrised debug display controller that drives seven-segment digits from multiple pages of register data. It sits between the datapath debug taps and the board display pins, replacing fixed per-digit decoders. It adds page selection with automatic page cycling, snapshot freeze, leading-zero blanking, blinking, and a time-multiplexed scan output for boards with shared segment lines. All outputs are registered and active-low.

---
 rtl/hexdisp_pkg.sv | 19 +
 rtl/hex7_decode.sv | 15 +
 rtl/hex_display_ctrl.sv | 159 +++++++++++++++
 tb/tb_hex_display_ctrl.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/hexdisp_pkg.sv
// Shared types and constants for the hex display controller.
package hexdisp_pkg;

  typedef enum logic [1:0] {
    MODE_MANUAL = 2'd0,
    MODE_AUTO   = 2'd1,
    MODE_FREEZE = 2'd2
  } mode_e;

  // All segments off (outputs are active-low).
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Active-high glyphs, bit 0 = seg a; entry n is the glyph for nibble n (listed F down to 0).
  localparam logic [15:0][6:0] GLYPH_TABLE = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

endpackage

// File: rtl/hex7_decode.sv
// Combinational nibble to active-low seven-segment decoder with blank override.
module hex7_decode
  import hexdisp_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       blank,
  output logic [6:0] seg
);

  // Blank wins over the glyph; glyph table is active-high so invert it.
  always_comb begin
    seg = blank ? SEG_BLANK : ~GLYPH_TABLE[nibble];
  end

endmodule

// File: rtl/hex_display_ctrl.sv
// Multi-page debug display controller: page select/auto-cycle/freeze, leading-zero
// blanking, blinking and a time-multiplexed scan output. All outputs registered, active-low.
module hex_display_ctrl
  import hexdisp_pkg::*;
#(
  parameter int unsigned DIGITS    = 4,
  parameter int unsigned PAGES     = 4,
  parameter int unsigned SCAN_DIV  = 16,
  parameter int unsigned DWELL     = 2**20,
  parameter int unsigned BLINK_DIV = 2**22
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [PAGES*DIGITS*4-1:0]   page_data,
  input  logic [$clog2(PAGES)-1:0]    page_sel,
  input  logic [1:0]                  mode,
  input  logic                        blank_lz,
  input  logic                        blink_en,
  output logic [DIGITS*7-1:0]         hex_static,
  output logic [6:0]                  seg_mux,
  output logic [DIGITS-1:0]           dig_en,
  output logic [$clog2(PAGES)-1:0]    cur_page,
  output logic                        page_change
);

  localparam int unsigned PW = $clog2(PAGES);
  localparam int unsigned IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int unsigned SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned DW = $clog2(DWELL);
  localparam int unsigned BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  logic [PAGES-1:0][DIGITS-1:0][3:0] pages;
  logic [DIGITS-1:0][3:0]            live, disp, snap_q, snap_d;
  logic [DIGITS-1:0]                 blank;
  logic                              seen_nz, blink_off;

  mode_e           mode_eff, mode_q;
  logic [PW-1:0]   page_q, page_d;
  logic [DW-1:0]   dwell_q, dwell_d;
  logic [BW-1:0]   blink_cnt_q, blink_cnt_d;
  logic            phase_q, phase_d;
  logic [SW-1:0]   scan_cnt_q, scan_cnt_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [DIGITS*7-1:0] hex_d;
  logic [6:0]      seg_mux_d;
  logic [DIGITS-1:0] dig_en_d;

  assign pages = page_data;

  // Mode 3 is folded into MANUAL.
  always_comb begin
    case (mode)
      2'd1:    mode_eff = MODE_AUTO;
      2'd2:    mode_eff = MODE_FREEZE;
      default: mode_eff = MODE_MANUAL;
    endcase
  end

  // Page FSM: next page, dwell counter and freeze snapshot selection.
  always_comb begin
    page_d  = page_q;
    dwell_d = '0;
    case (mode_eff)
      MODE_MANUAL: page_d = page_sel;
      MODE_AUTO: begin
        // On entry the counter restarts from zero and the current page is kept.
        if (mode_q != MODE_AUTO) begin
          dwell_d = '0;
        end else if (dwell_q == DW'(DWELL - 1)) begin
          page_d = page_q + 1'b1;
        end else begin
          dwell_d = dwell_q + 1'b1;
        end
      end
      default: page_d = page_q;
    endcase
    live   = pages[page_d];
    // Capture the live nibbles on the FREEZE entry cycle so the display never glitches.
    snap_d = ((mode_eff == MODE_FREEZE) && (mode_q != MODE_FREEZE)) ? live : snap_q;
    disp   = (mode_eff == MODE_FREEZE) ? snap_d : live;
  end

  // Blink and scan timebases; outputs use the next-state values to stay aligned.
  always_comb begin
    blink_cnt_d = blink_cnt_q + 1'b1;
    phase_d     = phase_q;
    if (blink_cnt_q == BW'(BLINK_DIV - 1)) begin
      blink_cnt_d = '0;
      phase_d     = ~phase_q;
    end
    scan_cnt_d = scan_cnt_q + 1'b1;
    idx_d      = idx_q;
    if (scan_cnt_q == SW'(SCAN_DIV - 1)) begin
      scan_cnt_d = '0;
      idx_d      = (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + 1'b1;
    end
    dig_en_d        = '1;
    dig_en_d[idx_d] = 1'b0;
  end

  // Per-digit blank flags: leading zeros from the top digit down, plus blink.
  always_comb begin
    blink_off = blink_en && phase_d;
    seen_nz   = 1'b0;
    blank     = '0;
    for (int d = int'(DIGITS) - 1; d >= 0; d--) begin
      if (disp[d] != 4'h0) seen_nz = 1'b1;
      blank[d] = (blank_lz && !seen_nz && (d != 0)) || blink_off;
    end
  end

  for (genvar g = 0; g < DIGITS; g++) begin : g_dec
    hex7_decode u_dec (
      .nibble (disp[g]),
      .blank  (blank[g]),
      .seg    (hex_d[g*7 +: 7])
    );
  end

  hex7_decode u_dec_mux (
    .nibble (disp[idx_d]),
    .blank  (blank[idx_d]),
    .seg    (seg_mux_d)
  );

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q      <= MODE_MANUAL;
      page_q      <= '0;
      dwell_q     <= '0;
      snap_q      <= '0;
      blink_cnt_q <= '0;
      phase_q     <= 1'b0;
      scan_cnt_q  <= '0;
      idx_q       <= '0;
      hex_static  <= '1;
      seg_mux     <= SEG_BLANK;
      dig_en      <= '1;
      page_change <= 1'b0;
    end else begin
      mode_q      <= mode_eff;
      page_q      <= page_d;
      dwell_q     <= dwell_d;
      snap_q      <= snap_d;
      blink_cnt_q <= blink_cnt_d;
      phase_q     <= phase_d;
      scan_cnt_q  <= scan_cnt_d;
      idx_q       <= idx_d;
      hex_static  <= hex_d;
      seg_mux     <= seg_mux_d;
      dig_en      <= dig_en_d;
      page_change <= (page_d != page_q);
    end
  end

  assign cur_page = page_q;

endmodule

// File: tb/tb_hex_display_ctrl.sv
// Directed self-checking bench for hex_display_ctrl (DIGITS=4, PAGES=4, SCAN_DIV=4,
// DWELL=8, BLINK_DIV=4).
module tb_hex_display_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [63:0] page_data;
  logic [1:0]  page_sel;
  logic [1:0]  mode;
  logic        blank_lz;
  logic        blink_en;
  logic [27:0] hex_static;
  logic [6:0]  seg_mux;
  logic [3:0]  dig_en;
  logic [1:0]  cur_page;
  logic        page_change;

  int tests_run    = 0;
  int tests_failed = 0;

  localparam logic [27:0] H_12AF    = {7'h79, 7'h24, 7'h08, 7'h0E};
  localparam logic [27:0] H_0040_LZ = {7'h7F, 7'h7F, 7'h19, 7'h40};
  localparam logic [27:0] H_0000_LZ = {7'h7F, 7'h7F, 7'h7F, 7'h40};
  localparam logic [27:0] H_0000    = {7'h40, 7'h40, 7'h40, 7'h40};
  localparam logic [27:0] H_BEEF    = {7'h03, 7'h06, 7'h06, 7'h0E};
  localparam logic [27:0] H_BLANK   = 28'hFFF_FFFF;

  logic [6:0] g12af [4];

  hex_display_ctrl #(
    .DIGITS    (4),
    .PAGES     (4),
    .SCAN_DIV  (4),
    .DWELL     (8),
    .BLINK_DIV (4)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .page_data   (page_data),
    .page_sel    (page_sel),
    .mode        (mode),
    .blank_lz    (blank_lz),
    .blink_en    (blink_en),
    .hex_static  (hex_static),
    .seg_mux     (seg_mux),
    .dig_en      (dig_en),
    .cur_page    (cur_page),
    .page_change (page_change)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp)
    else begin
      tests_failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, " hex"},    32'(hex_static),  32'(H_BLANK));
    check({tag, " seg"},    32'(seg_mux),     32'h7F);
    check({tag, " dig_en"}, 32'(dig_en),      32'hF);
    check({tag, " page"},   32'(cur_page),    32'h0);
    check({tag, " pchg"},   32'(page_change), 32'h0);
  endtask

  initial begin
    logic [3:0]  exp_en;
    logic [1:0]  exp_pg;
    int          idx;

    g12af[0] = 7'h0E; g12af[1] = 7'h08; g12af[2] = 7'h24; g12af[3] = 7'h79;

    // Reset and decode.
    rst_n     = 1'b0;
    mode      = 2'd0;
    page_sel  = 2'd2;
    blank_lz  = 1'b0;
    blink_en  = 1'b0;
    page_data = {16'h0000, 16'h12AF, 16'hBEEF, 16'h0040};
    #23;
    check_reset("rst");
    tick();
    rst_n = 1'b1;
    tick();
    check("dec hex", 32'(hex_static), 32'(H_12AF));
    check("dec page", 32'(cur_page), 32'h2);
    check("dec pchg", 32'(page_change), 32'h1);
    check("dec dig_en", 32'(dig_en), 32'hE);
    for (int k = 2; k <= 17; k++) begin
      tick();
      idx = (k / 4) % 4;
      exp_en = 4'hF;
      exp_en[idx] = 1'b0;
      check("scan dig_en", 32'(dig_en), 32'(exp_en));
      check("scan seg", 32'(seg_mux), 32'(g12af[idx]));
    end
    check("pchg low", 32'(page_change), 32'h0);

    // Leading-zero blanking.
    blank_lz = 1'b1;
    page_sel = 2'd0;
    tick();
    check("lz 0040", 32'(hex_static), 32'(H_0040_LZ));
    page_data[15:0] = 16'h0000;
    tick();
    check("lz 0000", 32'(hex_static), 32'(H_0000_LZ));

    // AUTO cycling from page 3.
    page_data[15:0] = 16'h0040;
    page_sel = 2'd3;
    tick();
    check("auto pre page", 32'(cur_page), 32'h3);
    mode = 2'd1;
    tick();
    check("auto e0 page", 32'(cur_page), 32'h3);
    check("auto e0 pchg", 32'(page_change), 32'h0);
    check("auto e0 hex", 32'(hex_static), 32'(H_0000_LZ));
    for (int i = 1; i <= 23; i++) begin
      tick();
      exp_pg = (i < 8) ? 2'd3 : ((i < 16) ? 2'd0 : 2'd1);
      check("auto page", 32'(cur_page), 32'(exp_pg));
      check("auto pchg", 32'(page_change), 32'((i == 8) || (i == 16)));
      if (i == 8) check("auto e8 hex", 32'(hex_static), 32'(H_0040_LZ));
    end
    // Dwell is at terminal count; leaving AUTO now must suppress the increment.
    mode = 2'd0;
    page_sel = 2'd1;
    tick();
    check("abort page", 32'(cur_page), 32'h1);
    check("abort pchg", 32'(page_change), 32'h0);

    // FREEZE snapshot.
    blank_lz = 1'b0;
    tick();
    check("pre frz hex", 32'(hex_static), 32'(H_BEEF));
    mode = 2'd2;
    tick();
    check("frz entry", 32'(hex_static), 32'(H_BEEF));
    page_data[31:16] = 16'h0000;
    page_sel = 2'd2;
    tick();
    check("frz hold hex", 32'(hex_static), 32'(H_BEEF));
    check("frz hold page", 32'(cur_page), 32'h1);
    tick();
    check("frz hold2 hex", 32'(hex_static), 32'(H_BEEF));
    mode = 2'd0;
    page_sel = 2'd1;
    tick();
    check("unfrz hex", 32'(hex_static), 32'(H_0000));

    // Blink from a fresh reset, then async reset mid-pattern.
    rst_n = 1'b0;
    #1;
    check_reset("rst2");
    page_data[47:32] = 16'h12AF;
    page_sel = 2'd2;
    blink_en = 1'b1;
    tick();
    rst_n = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      tick();
      idx = (k / 4) % 4;
      if (((k / 4) % 2) == 1) begin
        check("blink hex", 32'(hex_static), 32'(H_BLANK));
        check("blink seg", 32'(seg_mux), 32'h7F);
      end else begin
        check("vis hex", 32'(hex_static), 32'(H_12AF));
        check("vis seg", 32'(seg_mux), 32'(g12af[idx]));
      end
    end
    #2;
    rst_n = 1'b0;
    #1;
    check_reset("async rst");
    tick();
    check_reset("held rst");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
